// File: rtl/ram_map_pkg.sv
// Address map, FSM state type and static map checks for the region-mapped bus RAM.
package ram_map_pkg;

    localparam int unsigned NUM_REGIONS = 4;

    localparam logic [31:0] REGION_BASE [NUM_REGIONS] =
        '{32'h0000_0000, 32'h8000_0000, 32'hBFC0_0000, 32'hFFFF_FC00};
    localparam logic [31:0] REGION_SIZE [NUM_REGIONS] =
        '{32'h0000_0400, 32'h0000_1000, 32'h0000_0800, 32'h0000_0400};
    localparam logic [31:0] REGION_OFFSET [NUM_REGIONS] =
        '{32'h0000_0000, 32'h0000_0400, 32'h0000_1400, 32'h0000_1C00};

    typedef enum logic [1:0] {
        RESET,
        CLEAR,
        READY
    } state_t;

    // 33-bit ends so the window ending at 4 GiB does not wrap.
    function automatic bit regions_disjoint();
        logic [32:0] a_lo, a_hi, b_lo, b_hi;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            for (int unsigned j = i + 1; j < NUM_REGIONS; j++) begin
                a_lo = {1'b0, REGION_BASE[i]};
                a_hi = a_lo + {1'b0, REGION_SIZE[i]};
                b_lo = {1'b0, REGION_BASE[j]};
                b_hi = b_lo + {1'b0, REGION_SIZE[j]};
                if ((a_lo < b_hi) && (b_lo < a_hi)) begin
                    return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    function automatic bit regions_fit(input int unsigned depth_bytes);
        logic [32:0] top;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            top = {1'b0, REGION_OFFSET[i]} + {1'b0, REGION_SIZE[i]};
            if (top > 33'(depth_bytes)) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/ram_addr_map.sv
// Combinational decoder: bus byte address -> region hit, array word index, misalignment.
module ram_addr_map
    import ram_map_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 11
) (
    input  logic [31:0]      address_i,
    output logic             hit_c,
    output logic [IDX_W-1:0] word_idx_c,
    output logic             misaligned_c
);

    localparam int unsigned LSB = $clog2(DATA_W / 8);

    logic [31:0] rel_c;
    logic [31:0] phys_c;

    // Unsigned offset compare; first matching region wins.
    always_comb begin
        hit_c  = 1'b0;
        rel_c  = '0;
        phys_c = '0;
        for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
            rel_c = address_i - REGION_BASE[r];
            if (!hit_c && (rel_c < REGION_SIZE[r])) begin
                hit_c  = 1'b1;
                phys_c = rel_c + REGION_OFFSET[r];
            end
        end
    end

    assign word_idx_c   = IDX_W'(phys_c >> LSB);
    assign misaligned_c = (address_i & 32'(DATA_W / 8 - 1)) != 32'd0;

endmodule

// File: rtl/ram_mapped_bus.sv
// Region-mapped word RAM with byte enables, wait/valid handshake, pipelined reads,
// error responses and an optional post-reset clear sequencer.
module ram_mapped_bus
    import ram_map_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH_BYTES    = 8192,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b0,
    parameter string       RAM_INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     writedata,
    output logic                  waitrequest,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  err
);

    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned WORDS     = DEPTH_BYTES / BYTES;
    localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LAST_WORD = WORDS - 1;

    logic [DATA_W-1:0]       mem_q [WORDS];
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic                    clr_we_c;
    logic                    waitrequest_d;

    logic                    hit_c;
    logic                    misaligned_c;
    logic [IDX_W-1:0]        word_idx_c;
    logic                    accept_c, reject_c, wr_en_c, rd_en_c;
    logic [DATA_W-1:0]       rd_word_c;

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]       data_q [READ_LATENCY];

    ram_addr_map #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_addr_map (
        .address_i    (address),
        .hit_c        (hit_c),
        .word_idx_c   (word_idx_c),
        .misaligned_c (misaligned_c)
    );

    assign accept_c  = (read || write) && !waitrequest;
    assign reject_c  = !hit_c || misaligned_c || (read && write);
    assign wr_en_c   = accept_c && write && !reject_c;
    assign rd_en_c   = accept_c && read;
    assign rd_word_c = reject_c ? '0 : mem_q[word_idx_c];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET;
            clr_cnt_q   <= '0;
            waitrequest <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            waitrequest <= waitrequest_d;
        end
    end

    // Next state, clear sequencing; waitrequest follows the state being entered.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we_c  = 1'b0;
        unique case (state_q)
            RESET: begin
                clr_cnt_d = '0;
                state_d   = CLEAR_ON_RESET ? CLEAR : READY;
            end
            CLEAR: begin
                clr_we_c = 1'b1;
                if (clr_cnt_q == IDX_W'(LAST_WORD)) begin
                    state_d = READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = RESET;
            end
        endcase
        waitrequest_d = (state_d != READY);
    end

    // Array contents survive reset; clear and bus writes never coincide.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en_c) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (byteenable[b]) begin
                    mem_q[word_idx_c][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    // Read shift pipeline; data stages load only behind a valid so readdata holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            err   <= 1'b0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            err      <= accept_c && reject_c;
            vld_q[0] <= rd_en_c;
            if (rd_en_c) begin
                data_q[0] <= rd_word_c;
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign readdata      = data_q[READ_LATENCY-1];
    assign readdatavalid = vld_q[READ_LATENCY-1];

    // Static configuration guard; file preload is not supported by this array.
    localparam bit CFG_OK = regions_disjoint() && regions_fit(DEPTH_BYTES) &&
                            (DATA_W % 8 == 0) && (DATA_W >= 8) && (DATA_W <= 64) &&
                            (READ_LATENCY >= 1) && (READ_LATENCY <= 4) &&
                            (RAM_INIT_FILE == "");

    cfg_ok_a: assert property (@(posedge clk) CFG_OK);

endmodule

// File: tb/tb_ram_mapped_bus.sv
// Scoreboard bench for ram_mapped_bus: clear length, byte enables, latency, errors, reset flush.
module tb_ram_mapped_bus;

    localparam int unsigned RL    = 3;
    localparam int unsigned WORDS = 2048;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read, write;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        err;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_wait;

    ram_mapped_bus #(
        .DATA_W         (32),
        .DEPTH_BYTES    (8192),
        .READ_LATENCY   (RL),
        .CLEAR_ON_RESET (1'b1),
        .RAM_INIT_FILE  ("")
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .read          (read),
        .write         (write),
        .address       (address),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .err           (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pop one expectation per readdatavalid; also checks the delivery cycle.
    always @(negedge clk) begin
        if (readdatavalid !== 1'b0) begin
            if (sb.size() == 0) begin
                check("rdv_spurious", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", readdata, mon_e.data);
                check("rdv_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic bus_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        int tries = 0;
        @(negedge clk);
        read = rd; write = wr; address = addr; byteenable = be; writedata = wd;
        while (waitrequest !== 1'b0 && tries < 5000) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 5000) begin
            check("accept_timeout", 32'd1, 32'd0);
            read = 1'b0; write = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (rd) sb.push_back('{exp_rd, cyc + RL - 1});
        check("err", {31'd0, err}, {31'd0, exp_err});
        read = 1'b0; write = 1'b0;
    endtask

    task automatic wr_op(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                         input logic exp_err);
        bus_op(1'b0, 1'b1, addr, be, wd, 32'd0, exp_err);
    endtask

    task automatic rd_op(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err);
        bus_op(1'b1, 1'b0, addr, 4'h0, 32'd0, exp, exp_err);
    endtask

    task automatic drain();
        repeat (RL + 3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic count_wait(output int n);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (waitrequest === 1'b1) n++;
            else break;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wait"}, {31'd0, waitrequest}, 32'd1);
        check({tag, "_rdata"}, readdata, 32'd0);
        check({tag, "_rdv"}, {31'd0, readdatavalid}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        count_wait(n_wait);
        check("clear_len", 32'(n_wait), 32'(WORDS));
        rd_op(32'h0000_0010, 32'h0, 1'b0);

        // Byte-enabled write, read in the very next cycle; be=0 is a no-op.
        wr_op(32'h8000_0004, 4'b0101, 32'hDEAD_BEEF, 1'b0);
        rd_op(32'h8000_0004, 32'h00AD_00EF, 1'b0);
        wr_op(32'h8000_0004, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        rd_op(32'h8000_0004, 32'h00AD_00EF, 1'b0);
        wr_op(32'h8000_0004, 4'b1000, 32'h7700_0000, 1'b0);
        rd_op(32'h8000_0004, 32'h77AD_00EF, 1'b0);

        // Back-to-back reads return in order, one per cycle.
        wr_op(32'h0000_0000, 4'hF, 32'h1111_1111, 1'b0);
        wr_op(32'h0000_0004, 4'hF, 32'h2222_2222, 1'b0);
        wr_op(32'h0000_0008, 4'hF, 32'h3333_3333, 1'b0);
        rd_op(32'h0000_0000, 32'h1111_1111, 1'b0);
        rd_op(32'h0000_0004, 32'h2222_2222, 1'b0);
        rd_op(32'h0000_0008, 32'h3333_3333, 1'b0);
        drain();
        check("rdata_hold", readdata, 32'h3333_3333);

        // Rejected accesses: unmapped, misaligned, read+write together.
        rd_op(32'h4000_0000, 32'h0, 1'b1);
        rd_op(32'h0000_0002, 32'h0, 1'b1);
        wr_op(32'h0000_0002, 4'hF, 32'hBAD0_BAD0, 1'b1);
        wr_op(32'h4000_0000, 4'hF, 32'hBAD0_BAD0, 1'b1);
        bus_op(1'b1, 1'b1, 32'h0000_0004, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b1);
        rd_op(32'h0000_0000, 32'h1111_1111, 1'b0);
        rd_op(32'h0000_0004, 32'h2222_2222, 1'b0);

        // Top-of-space region and window edges.
        wr_op(32'hFFFF_FC00, 4'hF, 32'h1234_5678, 1'b0);
        rd_op(32'hFFFF_FC00, 32'h1234_5678, 1'b0);
        rd_op(32'h0000_0000, 32'h1111_1111, 1'b0);
        wr_op(32'hFFFF_FFFC, 4'hF, 32'hA5A5_5A5A, 1'b0);
        rd_op(32'hFFFF_FFFC, 32'hA5A5_5A5A, 1'b0);
        wr_op(32'h0000_03FC, 4'hF, 32'h3C3C_3C3C, 1'b0);
        rd_op(32'h0000_03FC, 32'h3C3C_3C3C, 1'b0);
        rd_op(32'h0000_0400, 32'h0, 1'b1);
        wr_op(32'h8000_0FFC, 4'hF, 32'h0F0F_0F0F, 1'b0);
        rd_op(32'h8000_0FFC, 32'h0F0F_0F0F, 1'b0);
        rd_op(32'h8000_1000, 32'h0, 1'b1);
        wr_op(32'hBFC0_07FC, 4'hF, 32'h5566_7788, 1'b0);
        rd_op(32'hBFC0_07FC, 32'h5566_7788, 1'b0);
        rd_op(32'hBFC0_0800, 32'h0, 1'b1);
        drain();

        // Reset with two reads in flight: both are dropped.
        rd_op(32'h0000_0000, 32'h1111_1111, 1'b0);
        rd_op(32'h0000_0004, 32'h2222_2222, 1'b0);
        reset_n = 1'b0;
        sb.delete();
        repeat (6) @(negedge clk);
        check_reset_outputs("flush");
        reset_n = 1'b1;

        // Reset mid-clear restarts the full sweep.
        repeat (100) @(negedge clk);
        check("mid_clear_wait", {31'd0, waitrequest}, 32'd1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        count_wait(n_wait);
        check("reclear_len", 32'(n_wait), 32'(WORDS));
        rd_op(32'h0000_0000, 32'h0, 1'b0);
        rd_op(32'hFFFF_FFFC, 32'h0, 1'b0);
        rd_op(32'h8000_0004, 32'h0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
